// File: rtl/demux_1ne2_stream_if.sv
// Handshake bundle for the 1-to-2 stream demux: one input stream, two output
// streams with occupancy. The slave side is the demux, the master side is the environment.
interface demux_1ne2_stream_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 2
);
  logic [WIDTH-1:0] hyrja;
  logic             hyrja_valid;
  logic             Sinjali;
  logic             hyrja_ready;
  logic [WIDTH-1:0] dalja0;
  logic             dalja0_valid;
  logic             dalja0_ready;
  logic [WIDTH-1:0] dalja1;
  logic             dalja1_valid;
  logic             dalja1_ready;
  logic [CW-1:0]    numri0;
  logic [CW-1:0]    numri1;

  modport master (
    output hyrja, hyrja_valid, Sinjali, dalja0_ready, dalja1_ready,
    input  hyrja_ready, dalja0, dalja0_valid, dalja1, dalja1_valid, numri0, numri1
  );

  modport slave (
    input  hyrja, hyrja_valid, Sinjali, dalja0_ready, dalja1_ready,
    output hyrja_ready, dalja0, dalja0_valid, dalja1, dalja1_valid, numri0, numri1
  );
endinterface

// File: rtl/demux_1ne2_stream.sv
// Buffered 1-to-2 stream demux: each accepted word is steered by Sinjali into
// one of two small FIFOs, each draining through its own valid/ready port.
module demux_1ne2_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic [CW-1:0]    cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wp, rp;

  // Pointers are power-of-two wide, so wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign vld  = (cnt != '0);
  // Storage is not reset; stale contents are hidden whenever the FIFO is empty.
  assign dout = vld ? mem[rp] : '0;
endmodule

module demux_1ne2_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic Clock,
  input logic Reset_n,
  demux_1ne2_stream_if.slave bus
);
  localparam int NDST = 2;

  logic [NDST-1:0][WIDTH-1:0] dout;
  logic [NDST-1:0][CW-1:0]    cnt;
  logic [NDST-1:0]            vld, full, push, pop, rdy_in;

  assign rdy_in = {bus.dalja1_ready, bus.dalja0_ready};

  // Ready looks only at the selected FIFO so a full one never stalls the other.
  assign bus.hyrja_ready = bus.Sinjali ? ~full[1] : ~full[0];

  generate
    for (genvar i = 0; i < NDST; i++) begin : g_dst
      assign full[i] = (cnt[i] == CW'(DEPTH));
      assign push[i] = bus.hyrja_valid & bus.hyrja_ready & (bus.Sinjali == 1'(i));
      assign pop[i]  = vld[i] & rdy_in[i];

      demux_1ne2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk  (Clock),
        .rst_n(Reset_n),
        .push (push[i]),
        .pop  (pop[i]),
        .din  (bus.hyrja),
        .dout (dout[i]),
        .vld  (vld[i]),
        .cnt  (cnt[i])
      );
    end
  endgenerate

  assign bus.dalja0       = dout[0];
  assign bus.dalja1       = dout[1];
  assign bus.dalja0_valid = vld[0];
  assign bus.dalja1_valid = vld[1];
  assign bus.numri0       = cnt[0];
  assign bus.numri1       = cnt[1];
endmodule

// File: tb/tb_demux_1ne2_stream.sv
// Directed vector table plus hand sequences and a queue-scoreboard random run
// for the 1-to-2 stream demux.
module tb_demux_1ne2_stream;
  logic Clock = 1'b0;
  logic Reset_n;
  int   nvec = 0;
  int   nerr = 0;

  demux_1ne2_stream_if #(.WIDTH(16), .CW(2)) bus();

  demux_1ne2_stream #(.WIDTH(16), .DEPTH(2), .CW(2)) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        vld, sel;
    logic [15:0] dat;
    logic        r0, r1;
    logic        er;
    logic        ev0;
    logic [15:0] ed0;
    logic        ev1;
    logic [15:0] ed1;
    logic [1:0]  en0, en1;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d,
                       input logic r0, input logic r1);
    bus.hyrja_valid  = v;
    bus.Sinjali      = s;
    bus.hyrja        = d;
    bus.dalja0_ready = r0;
    bus.dalja1_ready = r1;
  endtask

  task automatic check_outs(input string tag, input logic ev0, input logic [15:0] ed0,
                            input logic ev1, input logic [15:0] ed1,
                            input logic [1:0] en0, input logic [1:0] en1);
    check({tag, ".v0"}, 32'(bus.dalja0_valid), 32'(ev0));
    check({tag, ".d0"}, 32'(bus.dalja0), 32'(ed0));
    check({tag, ".v1"}, 32'(bus.dalja1_valid), 32'(ev1));
    check({tag, ".d1"}, 32'(bus.dalja1), 32'(ed1));
    check({tag, ".n0"}, 32'(bus.numri0), 32'(en0));
    check({tag, ".n1"}, 32'(bus.numri1), 32'(en1));
  endtask

  logic [15:0] q0[$], q1[$];

  initial begin
    //          vld sel dat       r0 r1  er  ev0 ed0       ev1 ed1      en0 en1
    tbl[0]  = '{1, 0, 16'h1234, 1, 1,  1,  1, 16'h1234, 0, 16'h0000, 2'd1, 2'd0};
    tbl[1]  = '{1, 1, 16'hABCD, 1, 1,  1,  0, 16'h0000, 1, 16'hABCD, 2'd0, 2'd1};
    tbl[2]  = '{0, 0, 16'h0000, 1, 1,  1,  0, 16'h0000, 0, 16'h0000, 2'd0, 2'd0};
    tbl[3]  = '{1, 0, 16'h0001, 0, 0,  1,  1, 16'h0001, 0, 16'h0000, 2'd1, 2'd0};
    tbl[4]  = '{1, 0, 16'h0002, 0, 0,  1,  1, 16'h0001, 0, 16'h0000, 2'd2, 2'd0};
    tbl[5]  = '{1, 0, 16'h0003, 0, 0,  0,  1, 16'h0001, 0, 16'h0000, 2'd2, 2'd0};
    tbl[6]  = '{1, 1, 16'h0003, 0, 0,  1,  1, 16'h0001, 1, 16'h0003, 2'd2, 2'd1};
    tbl[7]  = '{0, 0, 16'h0000, 1, 0,  0,  1, 16'h0002, 1, 16'h0003, 2'd1, 2'd1};
    tbl[8]  = '{0, 0, 16'h0000, 1, 1,  1,  0, 16'h0000, 0, 16'h0000, 2'd0, 2'd0};
    tbl[9]  = '{1, 0, 16'h0A0A, 0, 0,  1,  1, 16'h0A0A, 0, 16'h0000, 2'd1, 2'd0};
    tbl[10] = '{1, 0, 16'h0B0B, 1, 0,  1,  1, 16'h0B0B, 0, 16'h0000, 2'd1, 2'd0};
    tbl[11] = '{0, 0, 16'h0000, 1, 0,  1,  0, 16'h0000, 0, 16'h0000, 2'd0, 2'd0};
    tbl[12] = '{0, 1, 16'hFFFF, 1, 1,  1,  0, 16'h0000, 0, 16'h0000, 2'd0, 2'd0};

    Reset_n = 1'b0;
    drive(0, 0, 16'h0, 0, 0);
    @(negedge Clock);
    check("rst.ready", 32'(bus.hyrja_ready), 32'd1);
    check_outs("rst", 0, 16'h0, 0, 16'h0, 2'd0, 2'd0);
    Reset_n = 1'b1;

    // directed table
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].vld, tbl[i].sel, tbl[i].dat, tbl[i].r0, tbl[i].r1);
      #1;
      check($sformatf("vec%0d.ready", i), 32'(bus.hyrja_ready), 32'(tbl[i].er));
      @(posedge Clock);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].ev0, tbl[i].ed0, tbl[i].ev1, tbl[i].ed1,
                 tbl[i].en0, tbl[i].en1);
      @(negedge Clock);
    end

    // stream 10 words into port 1 with a toggling consumer
    begin
      int sent = 0;
      int got  = 0;
      for (int c = 0; c < 100 && got < 10; c++) begin
        drive(sent < 10, 1, 16'h0100 + 16'(sent), 0, c[0]);
        #1;
        if (bus.dalja1_valid && bus.dalja1_ready) begin
          check("stream.word", 32'(bus.dalja1), 32'h0100 + 32'(got));
          got++;
        end
        if (bus.hyrja_valid && bus.hyrja_ready) sent++;
        check("stream.n0", 32'(bus.numri0), 32'd0);
        @(posedge Clock);
        @(negedge Clock);
      end
      check("stream.count", 32'(got), 32'd10);
    end

    // fill both FIFOs, then a sub-cycle reset pulse
    for (int i = 0; i < 4; i++) begin
      drive(1, i[1], 16'hC000 + 16'(i), 0, 0);
      @(posedge Clock);
      @(negedge Clock);
    end
    drive(0, 0, 16'h0, 0, 0);
    check_outs("full", 1, 16'hC000, 1, 16'hC002, 2'd2, 2'd2);
    check("full.ready", 32'(bus.hyrja_ready), 32'd0);
    #1 Reset_n = 1'b0;
    #1;
    check_outs("arst", 0, 16'h0, 0, 16'h0, 2'd0, 2'd0);
    check("arst.ready", 32'(bus.hyrja_ready), 32'd1);
    #1 Reset_n = 1'b1;
    #1;
    check("rel.ready", 32'(bus.hyrja_ready), 32'd1);
    check("rel.n1", 32'(bus.numri1), 32'd0);
    @(negedge Clock);

    // random traffic against two reference queues
    q0.delete();
    q1.delete();
    for (int c = 0; c < 2000; c++) begin
      logic v, s, r0, r1, mr;
      logic [15:0] d;
      v  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      drive(v, s, d, r0, r1);
      #1;
      mr = s ? (q1.size() < 2) : (q0.size() < 2);
      check("rnd.ready", 32'(bus.hyrja_ready), 32'(mr));
      check("rnd.v0", 32'(bus.dalja0_valid), 32'(q0.size() != 0));
      check("rnd.v1", 32'(bus.dalja1_valid), 32'(q1.size() != 0));
      check("rnd.n0", 32'(bus.numri0), 32'(q0.size()));
      check("rnd.n1", 32'(bus.numri1), 32'(q1.size()));
      check("rnd.n0le", 32'(bus.numri0 <= 2'd2), 32'd1);
      check("rnd.n1le", 32'(bus.numri1 <= 2'd2), 32'd1);
      if (q0.size() != 0) check("rnd.d0", 32'(bus.dalja0), 32'(q0[0]));
      if (q1.size() != 0) check("rnd.d1", 32'(bus.dalja1), 32'(q1[0]));
      @(posedge Clock);
      if (r0 && q0.size() != 0) void'(q0.pop_front());
      if (r1 && q1.size() != 0) void'(q1.pop_front());
      if (v && mr) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end
      @(negedge Clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
